// File: rtl/dest_reg_pipe_if.sv
// rtl/dest_reg_pipe_if.sv - decode/issue bundle and hazard results for dest_reg_pipe
// Purpose: groups every non-clock/reset signal of dest_reg_pipe.
// Ports (seen from the pipe, slave modport):
//   in : dst_sel[1:0], rd, rt, issue, stall, flush, src_a, src_b
//   out: RdD, dest_q[DEPTH*REG_W], valid_q[DEPTH], hit_a/hit_b[DEPTH],
//        fwd_a_vld, fwd_b_vld, fwd_a_stg/fwd_b_stg[clog2(DEPTH)], pending_cnt[clog2(DEPTH+1)]
// The master modport is the decode side that drives instructions and consumes hazards.
interface dest_reg_pipe_if #(
  parameter int REG_W = 5,
  parameter int DEPTH = 3
);
  localparam int STG_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [1:0]             dst_sel;
  logic [REG_W-1:0]       rd;
  logic [REG_W-1:0]       rt;
  logic                   issue;
  logic                   stall;
  logic                   flush;
  logic [REG_W-1:0]       src_a;
  logic [REG_W-1:0]       src_b;

  logic [REG_W-1:0]       RdD;
  logic [DEPTH*REG_W-1:0] dest_q;
  logic [DEPTH-1:0]       valid_q;
  logic [DEPTH-1:0]       hit_a;
  logic [DEPTH-1:0]       hit_b;
  logic                   fwd_a_vld;
  logic                   fwd_b_vld;
  logic [STG_W-1:0]       fwd_a_stg;
  logic [STG_W-1:0]       fwd_b_stg;
  logic [CNT_W-1:0]       pending_cnt;

  modport master (
    output dst_sel, rd, rt, issue, stall, flush, src_a, src_b,
    input  RdD, dest_q, valid_q, hit_a, hit_b, fwd_a_vld, fwd_b_vld,
           fwd_a_stg, fwd_b_stg, pending_cnt
  );

  modport slave (
    input  dst_sel, rd, rt, issue, stall, flush, src_a, src_b,
    output RdD, dest_q, valid_q, hit_a, hit_b, fwd_a_vld, fwd_b_vld,
           fwd_a_stg, fwd_b_stg, pending_cnt
  );
endinterface

// File: rtl/dest_reg_pipe.sv
// rtl/dest_reg_pipe.sv - destination-register tracking pipe with hazard detection
// Purpose: tracks the destination register of each in-flight instruction for
//   DEPTH stages after decode and flags decode-stage sources that match a
//   pending write, pointing at the youngest producer.
// Ports:
//   clock  - single rising-edge clock
//   reset  - synchronous active-high reset, clears all stages
//   bus    - dest_reg_pipe_if.slave: decode inputs and hazard/status outputs
module dest_reg_pipe #(
  parameter int REG_W    = 5,
  parameter int LINK_REG = 31,
  parameter int DEPTH    = 3
) (
  input logic           clock,
  input logic           reset,
  dest_reg_pipe_if.slave bus
);
  localparam int STG_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [REG_W-1:0]       destQ [DEPTH];
  logic [DEPTH-1:0]       validQ;
  logic [REG_W-1:0]       rdSel;
  logic                   newValid;
  logic [DEPTH*REG_W-1:0] destFlat;
  logic [DEPTH-1:0]       hitA;
  logic [DEPTH-1:0]       hitB;
  logic [STG_W-1:0]       stgA;
  logic [STG_W-1:0]       stgB;
  logic [CNT_W-1:0]       cnt;

  // Destination decode is purely combinational and ignores reset.
  always_comb begin
    rdSel = '0;
    case (bus.dst_sel)
      2'b01:   rdSel = bus.rd;
      2'b10:   rdSel = bus.rt;
      2'b11:   rdSel = REG_W'(LINK_REG);
      default: rdSel = '0;
    endcase
  end

  // Register 0 is hardwired, so writes to it never create a hazard.
  assign newValid = bus.issue && !bus.flush && (rdSel != '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      validQ <= '0;
      for (int i = 0; i < DEPTH; i++) destQ[i] <= '0;
    end else if (bus.flush) begin
      // Flush only bubbles stage 0; older stages keep moving unless stalled.
      if (!bus.stall) begin
        for (int i = 1; i < DEPTH; i++) begin
          destQ[i]  <= destQ[i-1];
          validQ[i] <= validQ[i-1];
        end
      end
      destQ[0]  <= '0;
      validQ[0] <= 1'b0;
    end else if (!bus.stall) begin
      for (int i = 1; i < DEPTH; i++) begin
        destQ[i]  <= destQ[i-1];
        validQ[i] <= validQ[i-1];
      end
      destQ[0]  <= newValid ? rdSel : '0;
      validQ[0] <= newValid;
    end
  end

  // Hazards look only at registered state, never at the instruction issuing now.
  always_comb begin
    destFlat = '0;
    hitA     = '0;
    hitB     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      destFlat[i*REG_W +: REG_W] = destQ[i];
      hitA[i] = validQ[i] && (destQ[i] == bus.src_a) && (bus.src_a != '0);
      hitB[i] = validQ[i] && (destQ[i] == bus.src_b) && (bus.src_b != '0);
    end
  end

  // Scan oldest to youngest so the lowest-index match wins.
  always_comb begin
    stgA = '0;
    stgB = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (hitA[i]) stgA = STG_W'(i);
      if (hitB[i]) stgB = STG_W'(i);
    end
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) cnt = cnt + CNT_W'(validQ[i]);
  end

  assign bus.RdD         = rdSel;
  assign bus.dest_q      = destFlat;
  assign bus.valid_q     = validQ;
  assign bus.hit_a       = hitA;
  assign bus.hit_b       = hitB;
  assign bus.fwd_a_vld   = |hitA;
  assign bus.fwd_b_vld   = |hitB;
  assign bus.fwd_a_stg   = stgA;
  assign bus.fwd_b_stg   = stgB;
  assign bus.pending_cnt = cnt;
endmodule

// File: tb/tb_dest_reg_pipe.sv
// tb/tb_dest_reg_pipe.sv - self-checking bench for dest_reg_pipe
module tb_dest_reg_pipe;
  localparam int REG_W    = 5;
  localparam int DEPTH    = 3;
  localparam int LINK_REG = 31;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  dest_reg_pipe_if #(.REG_W(REG_W), .DEPTH(DEPTH)) bus ();

  dest_reg_pipe #(.REG_W(REG_W), .LINK_REG(LINK_REG), .DEPTH(DEPTH)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  // Pipeline model: queue element 0 is the youngest stage.
  typedef struct {
    bit v;
    int d;
  } ent_t;
  ent_t mq[$];

  typedef struct {
    bit       rst;
    bit [1:0] sel;
    int       rdv;
    int       rtv;
    bit       iss;
    bit       stl;
    bit       fl;
    int       sa;
    int       sb;
    int       eRdd;
    int       eValid;
    int       eHitA;
    int       eHitB;
    int       ePend;
  } vec_t;
  vec_t tbl[26];

  task automatic cmp(input string name, input logic [31:0] act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int selDest(input int sel, input int rdv, input int rtv);
    case (sel)
      1:       return rdv;
      2:       return rtv;
      3:       return LINK_REG;
      default: return 0;
    endcase
  endfunction

  task automatic drive(input bit rst, input bit [1:0] sel, input int rdv, input int rtv,
                       input bit iss, input bit stl, input bit fl, input int sa, input int sb);
    reset       = rst;
    bus.dst_sel = sel;
    bus.rd      = REG_W'(rdv);
    bus.rt      = REG_W'(rtv);
    bus.issue   = iss;
    bus.stall   = stl;
    bus.flush   = fl;
    bus.src_a   = REG_W'(sa);
    bus.src_b   = REG_W'(sb);
  endtask

  task automatic modelUpdate();
    ent_t e;
    int   rdd;
    rdd = selDest(int'(bus.dst_sel), int'(bus.rd), int'(bus.rt));
    if (reset) begin
      mq.delete();
      for (int i = 0; i < DEPTH; i++) mq.push_back('{1'b0, 0});
    end else if (bus.flush) begin
      if (!bus.stall) begin
        mq.push_front('{1'b0, 0});
        void'(mq.pop_back());
      end else begin
        mq[0] = '{1'b0, 0};
      end
    end else if (!bus.stall) begin
      e.v = bus.issue && (rdd != 0);
      e.d = e.v ? rdd : 0;
      mq.push_front(e);
      void'(mq.pop_back());
    end
  endtask

  task automatic checkModel(input string tag);
    int ha, hb, sa, sb, stA, stB, pend, vmask, rdd;
    sa = int'(bus.src_a);
    sb = int'(bus.src_b);
    ha = 0; hb = 0; pend = 0; vmask = 0; stA = -1; stB = -1;
    for (int i = 0; i < DEPTH; i++) begin
      if (mq[i].v) begin
        pend++;
        vmask |= (1 << i);
        if (mq[i].d == sa && sa != 0) begin ha |= (1 << i); if (stA < 0) stA = i; end
        if (mq[i].d == sb && sb != 0) begin hb |= (1 << i); if (stB < 0) stB = i; end
      end
      cmp($sformatf("%s dest_q[%0d]", tag, i), 32'(bus.dest_q[i*REG_W +: REG_W]), mq[i].d);
    end
    rdd = selDest(int'(bus.dst_sel), int'(bus.rd), int'(bus.rt));
    cmp({tag, " RdD"}, 32'(bus.RdD), rdd);
    cmp({tag, " valid_q"}, 32'(bus.valid_q), vmask);
    cmp({tag, " hit_a"}, 32'(bus.hit_a), ha);
    cmp({tag, " hit_b"}, 32'(bus.hit_b), hb);
    cmp({tag, " fwd_a_vld"}, 32'(bus.fwd_a_vld), (stA >= 0) ? 1 : 0);
    cmp({tag, " fwd_b_vld"}, 32'(bus.fwd_b_vld), (stB >= 0) ? 1 : 0);
    cmp({tag, " fwd_a_stg"}, 32'(bus.fwd_a_stg), (stA >= 0) ? stA : 0);
    cmp({tag, " fwd_b_stg"}, 32'(bus.fwd_b_stg), (stB >= 0) ? stB : 0);
    cmp({tag, " pending_cnt"}, 32'(bus.pending_cnt), pend);
  endtask

  task automatic tick();
    @(posedge clock);
    modelUpdate();
    @(negedge clock);
  endtask

  function automatic vec_t mk(input bit [1:0] sel, input int rdv, input int rtv, input bit iss,
                              input bit stl, input bit fl, input int sa, input int sb,
                              input int eRdd, input int eValid, input int eHitA,
                              input int eHitB, input int ePend);
    vec_t v;
    v = '{1'b0, sel, rdv, rtv, iss, stl, fl, sa, sb, eRdd, eValid, eHitA, eHitB, ePend};
    return v;
  endfunction

  initial begin
    for (int i = 0; i < DEPTH; i++) mq.push_back('{1'b0, 0});

    //          sel rd  rt  iss stl fl  sa  sb  RdD val hA  hB  pend
    tbl[0]  = mk(3, 5,  0,  0,  0,  0,  0,  0,  31, 0,  0,  0,  0);
    tbl[1]  = mk(0, 5,  0,  1,  0,  0,  0,  0,  0,  0,  0,  0,  0);
    tbl[2]  = mk(1, 7,  0,  1,  0,  0,  7,  0,  7,  0,  0,  0,  0);
    tbl[3]  = mk(0, 0,  0,  0,  0,  0,  7,  0,  0,  1,  1,  0,  1);
    tbl[4]  = mk(0, 0,  0,  0,  0,  0,  7,  0,  0,  2,  2,  0,  1);
    tbl[5]  = mk(0, 0,  0,  0,  0,  0,  7,  0,  0,  4,  4,  0,  1);
    tbl[6]  = mk(0, 0,  0,  0,  0,  0,  7,  0,  0,  0,  0,  0,  0);
    tbl[7]  = mk(2, 0,  9,  1,  0,  0,  0,  9,  9,  0,  0,  0,  0);
    tbl[8]  = mk(1, 9,  0,  1,  0,  0,  0,  9,  9,  1,  0,  1,  1);
    tbl[9]  = mk(0, 0,  0,  0,  0,  0,  0,  9,  0,  3,  0,  3,  2);
    tbl[10] = mk(0, 0,  0,  0,  0,  0,  0,  9,  0,  6,  0,  6,  2);
    tbl[11] = mk(0, 0,  0,  0,  0,  0,  0,  9,  0,  4,  0,  4,  1);
    tbl[12] = mk(0, 0,  0,  0,  0,  0,  0,  9,  0,  0,  0,  0,  0);
    tbl[13] = mk(1, 4,  0,  1,  0,  0,  4,  0,  4,  0,  0,  0,  0);
    tbl[14] = mk(1, 6,  0,  1,  1,  0,  4,  0,  6,  1,  1,  0,  1);
    tbl[15] = mk(1, 6,  0,  1,  1,  0,  4,  0,  6,  1,  1,  0,  1);
    tbl[16] = mk(1, 6,  0,  1,  1,  0,  4,  0,  6,  1,  1,  0,  1);
    tbl[17] = mk(0, 0,  0,  0,  1,  1,  4,  0,  0,  1,  1,  0,  1);
    tbl[18] = mk(0, 0,  0,  0,  0,  0,  4,  0,  0,  0,  0,  0,  0);
    tbl[19] = mk(1, 0,  0,  1,  0,  0,  0,  0,  0,  0,  0,  0,  0);
    tbl[20] = mk(0, 0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0);
    tbl[21] = mk(1, 3,  0,  1,  0,  0,  3,  0,  3,  0,  0,  0,  0);
    tbl[22] = mk(1, 12, 0,  1,  0,  1,  3,  12, 12, 1,  1,  0,  1);
    tbl[23] = mk(0, 0,  0,  0,  0,  0,  3,  12, 0,  2,  2,  0,  1);
    tbl[24] = mk(0, 0,  0,  0,  0,  0,  3,  12, 0,  4,  4,  0,  1);
    tbl[25] = mk(0, 0,  0,  0,  0,  0,  3,  12, 0,  0,  0,  0,  0);

    // Reset from power-up, then check cleared state while reset is still held.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    tick();
    drive(1, 3, 5, 0, 1, 0, 0, 31, 31);
    #1;
    cmp("reset valid_q", 32'(bus.valid_q), 0);
    cmp("reset pending_cnt", 32'(bus.pending_cnt), 0);
    cmp("reset hit_a", 32'(bus.hit_a), 0);
    cmp("reset RdD", 32'(bus.RdD), 31);
    tick();

    for (int k = 0; k < 26; k++) begin
      drive(tbl[k].rst, tbl[k].sel, tbl[k].rdv, tbl[k].rtv, tbl[k].iss, tbl[k].stl,
            tbl[k].fl, tbl[k].sa, tbl[k].sb);
      #1;
      cmp($sformatf("row%0d RdD", k), 32'(bus.RdD), tbl[k].eRdd);
      cmp($sformatf("row%0d valid_q", k), 32'(bus.valid_q), tbl[k].eValid);
      cmp($sformatf("row%0d hit_a", k), 32'(bus.hit_a), tbl[k].eHitA);
      cmp($sformatf("row%0d hit_b", k), 32'(bus.hit_b), tbl[k].eHitB);
      cmp($sformatf("row%0d pending_cnt", k), 32'(bus.pending_cnt), tbl[k].ePend);
      checkModel($sformatf("row%0d", k));
      tick();
    end

    // Fill all stages, then a single reset cycle that also stalls/flushes/issues.
    drive(0, 1, 1, 0, 1, 0, 0, 0, 0); tick();
    drive(0, 1, 2, 0, 1, 0, 0, 0, 0); tick();
    drive(0, 1, 3, 0, 1, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 2, 3);
    #1;
    cmp("full pending_cnt", 32'(bus.pending_cnt), 3);
    cmp("full valid_q", 32'(bus.valid_q), 7);
    cmp("full hit_a", 32'(bus.hit_a), 2);
    cmp("full fwd_a_stg", 32'(bus.fwd_a_stg), 1);
    cmp("full dest_q", 32'(bus.dest_q), (1 << 10) | (2 << 5) | 3);
    drive(1, 3, 0, 0, 1, 1, 1, 2, 3);
    #1;
    cmp("midreset RdD", 32'(bus.RdD), 31);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 2, 3);
    #1;
    cmp("postreset valid_q", 32'(bus.valid_q), 0);
    cmp("postreset pending_cnt", 32'(bus.pending_cnt), 0);
    cmp("postreset hit_a", 32'(bus.hit_a), 0);
    cmp("postreset hit_b", 32'(bus.hit_b), 0);
    cmp("postreset fwd_b_vld", 32'(bus.fwd_b_vld), 0);
    cmp("postreset dest_q", 32'(bus.dest_q), 0);
    tick();

    // Randomized traffic against the queue model.
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 39) == 0), 2'($urandom_range(0, 3)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            ($urandom_range(0, 1) == 1), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 5) == 0),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      #1;
      checkModel($sformatf("rnd%0d", n));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dest_reg_pipe.md
DEST_REG_PIPE -- requirements
Module: dest_reg_pipe

Interface
REQ-001 Parameter REG_W, default 5, register-address width.
REQ-002 Parameter LINK_REG, default 31, link-register address written by dst_sel=11.
REQ-003 Parameter DEPTH, default 3 (min 2), number of tracked stages after decode (stage 0 = E, stage DEPTH-1 = oldest).
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 dst_sel  input  2  destination select: 00 none, 01 rd, 10 rt, 11 LINK_REG.
REQ-007 rd  input  REG_W  rd field of decode-stage instruction.
REQ-008 rt  input  REG_W  rt field of decode-stage instruction.
REQ-009 issue  input  1  decode-stage instruction valid and advancing.
REQ-010 stall  input  1  freeze all stages.
REQ-011 flush  input  1  insert bubble into stage 0.
REQ-012 src_a, src_b  input  REG_W each  decode-stage source addresses to check.
REQ-013 RdD  output  REG_W  combinational selected destination.
REQ-014 dest_q  output  DEPTH*REG_W  stage i destination at bits [i*REG_W +: REG_W].
REQ-015 valid_q  output  DEPTH  stage i holds a pending register write.
REQ-016 hit_a, hit_b  output  DEPTH each  per-stage match masks.
REQ-017 fwd_a_vld, fwd_b_vld  output  1 each  any stage matches.
REQ-018 fwd_a_stg, fwd_b_stg  output  clog2(DEPTH) each  youngest (lowest-index) matching stage; 0 when no match.
REQ-019 pending_cnt  output  clog2(DEPTH+1)  number of set bits in valid_q.

Function
REQ-020 RdD SHALL be 0 for dst_sel=00, rd for 01, rt for 10, LINK_REG for 11, purely combinational, independent of reset.
REQ-021 An entry SHALL be valid only if issue=1, flush=0 and RdD!=0; writes to register 0 are never tracked.
REQ-022 stall=0, flush=0: stage i+1 <= stage i for all i; stage 0 <= {valid per REQ-021, RdD}; stage DEPTH-1 contents are discarded.
REQ-023 stall=1, flush=0: all stages SHALL hold; issue is ignored.
REQ-024 flush=1 (any stall): stage 0 <= {0, 0}; when stall=0 older stages still shift, when stall=1 stages 1..DEPTH-1 hold.
REQ-025 Invalid stages SHALL store dest 0.
REQ-026 hit_a[i] SHALL equal valid_q[i] && dest_q[i]==src_a && src_a!=0, combinational on registered state; same for hit_b with src_b.
REQ-027 fwd_x_vld = |hit_x; fwd_x_stg = index of lowest set bit of hit_x (priority to youngest producer).
REQ-028 Hazard outputs SHALL reflect state before the current edge (no bypass of the instruction being issued this cycle).
REQ-029 pending_cnt SHALL be the registered-state popcount, range 0..DEPTH, no wrap.
REQ-030 Latency: entry issued at edge N appears in stage k after edge N+k with no stalls; each stall cycle adds one.

Reset
REQ-031 reset=1 at a rising edge SHALL clear valid_q to 0 and every dest_q field to 0, overriding stall, flush and issue.
REQ-032 During and after reset: hit_a=hit_b=0, fwd_*_vld=0, fwd_*_stg=0, pending_cnt=0; RdD still follows REQ-020.
REQ-033 Reset asserted mid-operation SHALL discard all pending entries in one cycle.

Verification
REQ-034 dst_sel=11, rd=5 -> RdD=31; dst_sel=00 with issue -> no entry, pending_cnt unchanged.
REQ-035 Issue rd=7 (dst_sel=01), then 2 idle cycles, src_a=7 -> hit_a=001, 010, 100 on successive cycles, then 000 after the 4th edge.
REQ-036 Issue rt=9 then rd=9 back-to-back, src_b=9 -> hit_b=011, fwd_b_stg=0, fwd_b_vld=1.
REQ-037 Entry dest=4 in stage 0, stall=1 for 3 cycles -> dest_q/valid_q unchanged, pending_cnt=1; stall=1 with flush=1 -> stage 0 cleared, pending_cnt=0.
REQ-038 dst_sel=01 rd=0, issue=1 -> valid_q[0]=0; src_a=0 never hits.
REQ-039 Fill all DEPTH stages, assert reset one cycle -> valid_q=0, pending_cnt=0, all hits 0 next cycle.
